// File: rtl/prog_counter_pkg.sv
// Shared definitions for the programmable up/down counter: step-decision encoding
// and default widths.
package prog_counter_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_PRESC_W = 8;

  // What the next count value is built from on a cycle with no clear/load.
  typedef enum logic [2:0] {
    STEP_HOLD    = 3'd0,
    STEP_INC     = 3'd1,
    STEP_DEC     = 3'd2,
    STEP_WRAP_LO = 3'd3,
    STEP_WRAP_HI = 3'd4
  } step_e;

endpackage

// File: rtl/prog_counter_if.sv
// Control/status bundle of prog_counter. presc_div exists only when
// PROG_COUNTER_PRESCALE_EN is defined.
interface prog_counter_if #(
  parameter int unsigned WIDTH = 32
`ifdef PROG_COUNTER_PRESCALE_EN
  , parameter int unsigned PRESC_W = 8
`endif
);

  logic             en;
  logic             up;
  logic             sat_mode;
  logic [WIDTH-1:0] limit;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
`ifdef PROG_COUNTER_PRESCALE_EN
  logic [PRESC_W-1:0] presc_div;
`endif
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf_sticky;

  modport master (
`ifdef PROG_COUNTER_PRESCALE_EN
    output presc_div,
`endif
    output en, up, sat_mode, limit, clear, load, load_val, ovf_clr,
    input  count, tc, ovf_sticky
  );

  modport slave (
`ifdef PROG_COUNTER_PRESCALE_EN
    input  presc_div,
`endif
    input  en, up, sat_mode, limit, clear, load, load_val, ovf_clr,
    output count, tc, ovf_sticky
  );

endinterface

// File: rtl/prog_counter_prescaler.sv
// Step prescaler: tick on the enabled cycle where the internal count equals div,
// then restart from 0. Only instantiated under PROG_COUNTER_PRESCALE_EN.
module prog_counter_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_p1;
  logic               hit_p0;

  assign hit_p0 = (presc_p1 == div);
  assign tick   = en & hit_p0;

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      presc_p1 <= '0;
    end else if (clr) begin
      presc_p1 <= '0;
    end else if (en) begin
      presc_p1 <= hit_p0 ? '0 : presc_p1 + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with limit, wrap/saturate, load, clear, terminal-count
// pulse and sticky overflow. Optional step prescaler under PROG_COUNTER_PRESCALE_EN.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
`ifdef PROG_COUNTER_PRESCALE_EN
  , parameter int unsigned    PRESC_W = DEF_PRESC_W
`endif
) (
  input  logic           clk,
  input  logic           reset_l,
  prog_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_p1;
  logic             tc_p1;
  logic             ovf_p1;

  logic             tick_p0;
  logic             step_p0;
  logic             at_bound_p0;
  logic             bound_evt_p0;
  step_e            dec_p0;
  logic [WIDTH-1:0] count_nxt_p0;

  // Saturating at the top lands on limit and at the bottom on 0, which are the same
  // targets as the opposite-direction wraps, so both modes share WRAP_LO/WRAP_HI.
  function automatic step_e decide(input logic up, input logic sat, input logic at_bound);
    if (!at_bound) return up ? STEP_INC : STEP_DEC;
    if (up)        return sat ? STEP_WRAP_HI : STEP_WRAP_LO;
    return sat ? STEP_WRAP_LO : STEP_WRAP_HI;
  endfunction

  function automatic logic [WIDTH-1:0] step_value(input step_e d,
                                                  input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] lim);
    case (d)
      STEP_INC:     return cur + ONE;
      STEP_DEC:     return cur - ONE;
      STEP_WRAP_LO: return '0;
      STEP_WRAP_HI: return lim;
      default:      return cur;
    endcase
  endfunction

`ifdef PROG_COUNTER_PRESCALE_EN
  prog_counter_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk     (clk),
    .reset_l (reset_l),
    .en      (bus.en),
    .clr     (bus.clear | bus.load),
    .div     (bus.presc_div),
    .tick    (tick_p0)
  );
`else
  assign tick_p0 = 1'b1;
`endif

  // Stage p0: step decision and next-state mux
  assign step_p0      = bus.en & tick_p0 & ~bus.clear & ~bus.load;
  assign at_bound_p0  = bus.up ? (count_p1 >= bus.limit) : (count_p1 == '0);
  assign bound_evt_p0 = step_p0 & at_bound_p0;

  always_comb begin
    dec_p0       = STEP_HOLD;
    count_nxt_p0 = count_p1;
    if (step_p0) dec_p0 = decide(bus.up, bus.sat_mode, at_bound_p0);
    if (bus.clear)     count_nxt_p0 = RST_VAL;
    else if (bus.load) count_nxt_p0 = bus.load_val;
    else               count_nxt_p0 = step_value(dec_p0, count_p1, bus.limit);
  end

  // Stage p1: output registers
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      count_p1 <= RST_VAL;
      tc_p1    <= 1'b0;
      ovf_p1   <= 1'b0;
    end else begin
      count_p1 <= count_nxt_p0;
      tc_p1    <= bound_evt_p0;
      ovf_p1   <= bound_evt_p0 | (ovf_p1 & ~bus.ovf_clr);
    end
  end

  assign bus.count      = count_p1;
  assign bus.tc         = tc_p1;
  assign bus.ovf_sticky = ovf_p1;

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter (WIDTH=8, RST_VAL=0); the prescaler section runs
// only when PROG_COUNTER_PRESCALE_EN is defined.
module tb_prog_counter;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset_l;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

`ifdef PROG_COUNTER_PRESCALE_EN
  prog_counter_if #(.WIDTH(W), .PRESC_W(8)) bus();
  prog_counter #(.WIDTH(W), .RST_VAL(8'd0), .PRESC_W(8)) dut (
    .clk(clk), .reset_l(reset_l), .bus(bus)
  );
`else
  prog_counter_if #(.WIDTH(W)) bus();
  prog_counter #(.WIDTH(W), .RST_VAL(8'd0)) dut (
    .clk(clk), .reset_l(reset_l), .bus(bus)
  );
`endif

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] c, input logic t,
                            input logic o);
    chk({tag, ".count"}, bus.count, c);
    chk({tag, ".tc"}, {7'd0, bus.tc}, {7'd0, t});
    chk({tag, ".ovf"}, {7'd0, bus.ovf_sticky}, {7'd0, o});
  endtask

  logic [W-1:0] exp_cnt [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
  logic         exp_tc  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic         exp_ovf [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [W-1:0] dn_cnt  [4] = '{8'd1, 8'd0, 8'd0, 8'd0};
  logic         dn_tc   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    reset_l      = 1'b0;
    bus.en       = 1'b1;
    bus.up       = 1'b1;
    bus.sat_mode = 1'b0;
    bus.limit    = 8'd5;
    bus.clear    = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 8'd0;
    bus.ovf_clr  = 1'b0;
`ifdef PROG_COUNTER_PRESCALE_EN
    bus.presc_div = 8'd0;
`endif

    // reset held with en=1
    tick(); expect_out("rst0", 8'd0, 1'b0, 1'b0);
    tick(); expect_out("rst1", 8'd0, 1'b0, 1'b0);

    // wrap up to limit 5
    reset_l = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(); expect_out($sformatf("wrap%0d", i), exp_cnt[i], exp_tc[i], exp_ovf[i]);
    end

    // saturating down from 2; ovf cleared during the load cycle
    bus.sat_mode = 1'b1; bus.load = 1'b1; bus.load_val = 8'd2; bus.ovf_clr = 1'b1;
    tick(); expect_out("ld2", 8'd2, 1'b0, 1'b0);
    bus.load = 1'b0; bus.ovf_clr = 1'b0; bus.up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_out($sformatf("satdn%0d", i), dn_cnt[i], dn_tc[i], (i >= 2));
    end

    // down wrap at 0 goes to limit
    bus.sat_mode = 1'b0;
    tick(); expect_out("dnwrap", 8'd5, 1'b1, 1'b1);

    // load above limit, then up step is a bound event
    bus.up = 1'b1; bus.load = 1'b1; bus.load_val = 8'd9;
    tick(); expect_out("ld9", 8'd9, 1'b0, 1'b1);
    bus.load = 1'b0;
    tick(); expect_out("ld9up", 8'd0, 1'b1, 1'b1);
    tick(); expect_out("up1", 8'd1, 1'b0, 1'b1);
    bus.load = 1'b1; bus.clear = 1'b1;
    tick(); expect_out("ldclr", 8'd0, 1'b0, 1'b1);
    bus.clear = 1'b0;
    tick(); expect_out("ld9b", 8'd9, 1'b0, 1'b1);
    bus.load = 1'b0; bus.sat_mode = 1'b1;
    tick(); expect_out("sat9", 8'd5, 1'b1, 1'b1);
    tick(); expect_out("sathold", 8'd5, 1'b1, 1'b1);

    // down from above limit decrements normally
    bus.load = 1'b1; bus.load_val = 8'd9;
    tick();
    bus.load = 1'b0; bus.up = 1'b0;
    tick(); expect_out("dn9", 8'd8, 1'b0, 1'b1);

    // mid-count reset
    bus.sat_mode = 1'b0; bus.up = 1'b1; bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick(); tick(); tick(); expect_out("cnt3", 8'd3, 1'b0, 1'b1);
    reset_l = 1'b0;
    tick(); expect_out("midrst", 8'd0, 1'b0, 1'b0);
    reset_l = 1'b1;

    // bound event with ovf_clr: set wins
    bus.load = 1'b1; bus.load_val = 8'd5;
    tick();
    bus.load = 1'b0; bus.ovf_clr = 1'b1;
    tick(); expect_out("setwins", 8'd0, 1'b1, 1'b1);
    bus.en = 1'b0;
    tick(); expect_out("ovfclr", 8'd0, 1'b0, 1'b0);
    bus.ovf_clr = 1'b0;
    tick(); expect_out("enoff", 8'd0, 1'b0, 1'b0);

    // limit = 0: both directions stay at 0 and flag every step
    bus.en = 1'b1; bus.limit = 8'd0;
    tick(); expect_out("lim0up", 8'd0, 1'b1, 1'b1);
    bus.up = 1'b0;
    tick(); expect_out("lim0dn", 8'd0, 1'b1, 1'b1);

    // modulo arithmetic at full range
    bus.limit = 8'd255; bus.up = 1'b1; bus.load = 1'b1; bus.load_val = 8'd254;
    tick();
    bus.load = 1'b0;
    tick(); expect_out("full255", 8'd255, 1'b0, 1'b1);
    tick(); expect_out("full0", 8'd0, 1'b1, 1'b1);

`ifdef PROG_COUNTER_PRESCALE_EN
    begin
      logic [W-1:0] pc [6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
      bus.clear = 1'b1; bus.presc_div = 8'd2;
      tick();
      bus.clear = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick(); chk($sformatf("presc%0d", i), bus.count, pc[i]);
      end
      bus.clear = 1'b1; bus.presc_div = 8'd0;
      tick();
      bus.clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick(); chk($sformatf("presc0_%0d", i), bus.count, 8'(i + 1));
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
